rr_bus_arbiter: RTL and testbench
=================================

# rr_bus_arbiter

Round-robin bus arbiter with a tenure watchdog, sharing one bus among `N_MASTERS` requesters. It replaces fixed-priority granting with fair rotation, so a persistently requesting low-index master cannot starve the others. Each grant is held until the bus slave acknowledges with `bus_ack`. If no acknowledge arrives within `TIMEOUT` cycles, the arbiter revokes the grant and flags an error. The block sits between the master request lines and the shared bus mux and slave.

## Interface
- `N_MASTERS`, default 3: number of requesters; legal range ≥ 2.
- `TIMEOUT`, default 16: maximum grant tenure in cycles without `bus_ack`; legal range ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bus_req`  in  N_MASTERS  per-master request level; bit i belongs to master i.
- `bus_ack`  in  1  slave acknowledge; ends the current tenure.
- `bus_grant`  out  N_MASTERS  registered grant; one-hot or all-zero.
- `grant_idx`  out  $clog2(N_MASTERS)  binary index of the granted master; meaningful only while `bus_busy` = 1.
- `bus_busy`  out  1  registered; 1 while a grant is held.
- `timeout_err`  out  1  registered one-cycle pulse on a watchdog revoke.

## Operation
- State machine with two states:
  - IDLE: no grant held.
  - GRANT: one master holds the bus.
- Internal registers:
  - `ptr`: round-robin pointer; the master with the highest priority for the next arbitration.
  - `tcnt`: tenure counter, width $clog2(TIMEOUT+1).
- IDLE, `bus_req` == 0: stay in IDLE; outputs unchanged at zero.
- IDLE, `bus_req` ≠ 0: select the first set bit scanning `ptr`, `ptr`+1, …, wrapping modulo N_MASTERS.
  - Load the one-hot `bus_grant` and `grant_idx` for that master.
  - Set `bus_busy` = 1, `tcnt` = 0, next state GRANT.
- GRANT: `bus_grant` and `grant_idx` stay stable regardless of any `bus_req` change, including the granted master dropping its request.
- GRANT with `bus_ack` = 1:
  - Clear `bus_grant` and `bus_busy`.
  - `ptr` = (`grant_idx` + 1) mod N_MASTERS.
  - Next state IDLE; no error.
- GRANT with `bus_ack` = 0 and `tcnt` == TIMEOUT-1 (watchdog revoke):
  - Clear the grant and `bus_busy`; assert `timeout_err` for one cycle.
  - Advance `ptr` exactly as on `bus_ack`.
  - Next state IDLE.
- GRANT, otherwise: `tcnt` += 1; stay in GRANT.
- `bus_ack` and watchdog expiry on the same edge: the acknowledge wins. `timeout_err` stays 0.
- `bus_ack` sampled in IDLE is ignored; no state or pointer change.
- `ptr` wraps from N_MASTERS-1 to 0.
- `grant_idx` holds its last value in IDLE.
- Invariants:
  - `bus_grant` is never more than one-hot.
  - `bus_busy` == (`bus_grant` ≠ 0).
  - `timeout_err` is never high for two consecutive cycles.
- Reset (synchronous, takes priority over everything, including mid-tenure):
  - State IDLE; `bus_grant` = 0, `grant_idx` = 0, `bus_busy` = 0, `timeout_err` = 0.
  - `ptr` = 0, `tcnt` = 0.
  - An active grant is dropped at the reset edge, with no `timeout_err`.

## Timing
- Request to grant: a request sampled at edge k in IDLE gives `bus_grant` valid after edge k (visible in cycle k+1).
- Acknowledge to release: `bus_ack` sampled at edge m clears `bus_grant` after edge m.
- Back-to-back tenures: the next grant appears no earlier than after edge m+1, so there is a mandatory one-cycle all-zero gap between tenures.
- Maximum tenure: exactly TIMEOUT cycles of asserted grant. `timeout_err` is high in the first cycle after the grant drops.
- Worst-case wait for a continuously requesting master: (N_MASTERS-1) × (TIMEOUT+1) + 1 cycles from its request being sampled.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset values: hold `reset` 2 cycles with random `bus_req`/`bus_ack` → all outputs 0. Release with `bus_req`=3'b100 → next cycle `bus_grant`=3'b100, `grant_idx`=2, `bus_busy`=1.
- Fair rotation: `bus_req`=3'b111 held, `bus_ack` pulsed the cycle after each grant → grants 001, 0, 010, 0, 100, 0, 001. No `timeout_err`.
- Watchdog (TIMEOUT=4): `bus_req`=3'b010, no ack → `bus_grant`=010 for exactly 4 cycles, then 0 with `timeout_err`=1 for one cycle. Regrant 010 after the gap, since it is the sole requester.
- Ack/timeout coincidence (TIMEOUT=4): `bus_ack`=1 in the 4th grant cycle → grant released, `timeout_err` stays 0, `ptr` advances.
- Stability and ignored ack: during a grant to master 0, toggle `bus_req` to 3'b110 → `bus_grant` stays 001 until ack. `bus_ack`=1 in IDLE with `bus_req`=0 → no change.
- Reset mid-tenure: assert `reset` during the 3rd grant cycle → next cycle all outputs 0 and no error pulse. With `bus_req`=3'b011 after release, master 0 is granted first (`ptr` back to 0).

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: grants one master at a time, holds the grant until
// bus_ack, and revokes it with a one-cycle timeout_err after TIMEOUT cycles.
module rr_bus_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int TIMEOUT   = 16,
  localparam int IW       = $clog2(N_MASTERS),
  localparam int TW       = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] bus_req,
  input  logic                 bus_ack,
  output logic [N_MASTERS-1:0] bus_grant,
  output logic [IW-1:0]        grant_idx,
  output logic                 bus_busy,
  output logic                 timeout_err
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 err_q, err_d;

  logic [2*N_MASTERS-1:0] req_dbl;
  logic [N_MASTERS-1:0]   req_rot;
  logic                   found;
  logic [IW:0]            pick_sum;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          ptr_next;

  // Rotate requests so bit 0 is the pointer's master; the first set bit of the
  // rotated vector is the winner, and its offset is mapped back modulo N.
  always_comb begin
    req_dbl  = {bus_req, bus_req} >> ptr_q;
    req_rot  = req_dbl[N_MASTERS-1:0];
    found    = 1'b0;
    pick_sum = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (!found && req_rot[i]) begin
        found    = 1'b1;
        pick_sum = {1'b0, ptr_q} + (IW+1)'(i);
      end
    end
    if (pick_sum >= (IW+1)'(N_MASTERS)) begin
      pick_sum = pick_sum - (IW+1)'(N_MASTERS);
    end
    pick = pick_sum[IW-1:0];
  end

  assign ptr_next = (idx_q == IW'(N_MASTERS - 1)) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          grant_d = {{(N_MASTERS-1){1'b0}}, 1'b1} << pick;
          idx_d   = pick;
          tcnt_d  = '0;
        end
      end
      S_GRANT: begin
        // Acknowledge takes precedence over a coinciding watchdog expiry.
        if (bus_ack) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus_grant   = grant_q;
  assign grant_idx   = idx_q;
  assign bus_busy    = (state_q == S_GRANT);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed scenarios with literal
// expectations, then random traffic, all against a behavioural tenure model.
module tb_rr_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] bus_req;
  logic         bus_ack;
  logic [N-1:0] bus_grant;
  logic [1:0]   grant_idx;
  logic         bus_busy;
  logic         timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the bus, how many grant cycles have been visible so far,
  // and which master gets first look at the next arbitration.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_age   = 0;
  int m_ptr   = 0;
  bit m_err   = 1'b0;

  rr_bus_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_req     (bus_req),
    .bus_ack     (bus_ack),
    .bus_grant   (bus_grant),
    .grant_idx   (grant_idx),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    if (reset) begin
      m_busy = 0; m_owner = 0; m_age = 0; m_ptr = 0; m_err = 0;
    end else if (!m_busy) begin
      m_err = 0;
      for (int off = 0; off < N; off++) begin
        int c;
        c = (m_ptr + off) % N;
        if (!m_busy && bus_req[c]) begin
          m_busy = 1; m_owner = c; m_age = 1;
        end
      end
    end else begin
      m_err = 0;
      if (bus_ack) begin
        m_busy = 0; m_ptr = (m_owner + 1) % N;
      end else if (m_age == TO) begin
        m_busy = 0; m_err = 1; m_ptr = (m_owner + 1) % N;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int exp_grant;
    exp_grant = m_busy ? (1 << m_owner) : 0;
    chk("grant", int'(bus_grant), exp_grant);
    chk("grant_idx", int'(grant_idx), m_owner);
    chk("busy", int'(bus_busy), int'(m_busy));
    chk("timeout_err", int'(timeout_err), int'(m_err));
  endtask

  // One clock: model follows the DUT's edge, then outputs are compared at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input logic [N-1:0] r, input logic a);
    bus_req = r;
    bus_ack = a;
  endtask

  initial begin
    reset = 1'b1; bus_req = '0; bus_ack = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(N'($urandom), 1'($urandom));
      step();
    end
    chk("rst_grant", int'(bus_grant), 0);
    chk("rst_busy", int'(bus_busy), 0);
    chk("rst_err", int'(timeout_err), 0);
    chk("rst_idx", int'(grant_idx), 0);

    reset = 1'b0;
    drive(3'b100, 0); step();
    chk("first_grant", int'(bus_grant), 3'b100);
    chk("first_idx", int'(grant_idx), 2);
    chk("first_busy", int'(bus_busy), 1);
    drive(3'b100, 1); step();
    chk("first_release", int'(bus_grant), 0);

    // Fair rotation, ptr now 0
    drive(3'b111, 0); step(); chk("rot0", int'(bus_grant), 3'b001);
    drive(3'b111, 1); step(); chk("rot0_rel", int'(bus_grant), 0);
    drive(3'b111, 0); step(); chk("rot1", int'(bus_grant), 3'b010);
    drive(3'b111, 1); step(); chk("rot1_rel", int'(bus_grant), 0);
    drive(3'b111, 0); step(); chk("rot2", int'(bus_grant), 3'b100);
    drive(3'b111, 1); step(); chk("rot2_rel", int'(bus_grant), 0);
    drive(3'b111, 0); step(); chk("rot_wrap", int'(bus_grant), 3'b001);
    drive(3'b111, 1); step(); chk("rot_err", int'(timeout_err), 0);

    // Watchdog: exactly TO grant cycles, then error pulse, then regrant
    drive(3'b010, 0);
    for (int i = 0; i < TO; i++) begin
      step(); chk("wd_hold", int'(bus_grant), 3'b010);
    end
    step();
    chk("wd_drop", int'(bus_grant), 0);
    chk("wd_err", int'(timeout_err), 1);
    step();
    chk("wd_regrant", int'(bus_grant), 3'b010);
    chk("wd_err_pulse", int'(timeout_err), 0);
    drive(3'b010, 1); step();

    // Ack on the watchdog's expiry cycle: ack wins
    drive(3'b010, 0);
    for (int i = 0; i < TO; i++) step();
    chk("co_still_granted", int'(bus_grant), 3'b010);
    drive(3'b010, 1); step();
    chk("co_release", int'(bus_grant), 0);
    chk("co_no_err", int'(timeout_err), 0);
    drive(3'b111, 0); step();
    chk("co_ptr_adv", int'(bus_grant), 3'b100);
    drive(3'b111, 1); step();

    // Grant stability under request changes; ack in idle ignored
    drive(3'b001, 0); step(); chk("st_grant", int'(bus_grant), 3'b001);
    drive(3'b110, 0); step(); step();
    chk("st_hold", int'(bus_grant), 3'b001);
    drive(3'b110, 1); step(); chk("st_rel", int'(bus_grant), 0);
    drive(3'b000, 1); step();
    chk("idle_ack_grant", int'(bus_grant), 0);
    chk("idle_ack_err", int'(timeout_err), 0);
    drive(3'b111, 0); step(); chk("idle_ack_ptr", int'(bus_grant), 3'b010);
    drive(3'b111, 1); step();

    // Reset in the third grant cycle of master 0
    drive(3'b001, 0); step(); step(); step();
    chk("mr_pre", int'(bus_grant), 3'b001);
    reset = 1'b1; drive(3'b011, 0); step();
    chk("mr_grant", int'(bus_grant), 0);
    chk("mr_busy", int'(bus_busy), 0);
    chk("mr_err", int'(timeout_err), 0);
    reset = 1'b0; step();
    chk("mr_ptr0", int'(bus_grant), 3'b001);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive(N'($urandom), ($urandom_range(0, 9) < 2));
      step();
      if (timeout_err && m_err === 1'b0) ;
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
